// File: rtl/tdcomp_pkg.sv
// Shared types and constants for the time-domain comparator sequencer.
//   state_e   : conversion FSM states
//   outcome_e : result of a single race trial
package tdcomp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRace,
    StRecover,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OutPWin,
    OutNWin,
    OutTie,
    OutNone
  } outcome_e;

  // Cycles allowed in ARM or RACE before giving up.
  localparam int unsigned DefaultTimeout = 200;

endpackage

// File: rtl/tdcomp_edge_sync.sv
// 2-FF synchroniser with rising-edge detect for one asynchronous edge line.
//   clk      : system clock
//   rst_n    : synchronous reset, active low
//   async_in : asynchronous input from the analog bank
//   level    : synchronised level
//   rise     : one-cycle pulse on a synchronised rising edge
module tdcomp_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised level.
  logic [2:0] ff_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[1:0], async_in};
    end
  end

  assign level = ff_q[1];
  assign rise  = ff_q[1] & ~ff_q[2];

endmodule

// File: rtl/tdcomp_seq.sv
// Sequencer and readout for a bank of time-domain comparators. Arms a channel, launches
// repeated races, measures edge order and separation, and reports a majority decision.
//   clk, rst_n, ena          : clock, synchronous active-low reset, enable (low = reset)
//   start, ch_sel, trials    : conversion request, channel, trial count minus one
//   chop_en                  : toggle the input swap between trials
//   edge_p, edge_n           : asynchronous arrival edges from the bank
//   launch, swap             : registered one-hot controls to the selected channel
//   busy, done               : conversion in progress / end-of-conversion pulse
//   result, tie, err         : majority decision, equal votes, ARM timeout
//   delta, p_votes           : last valid edge separation, P-win count
module tdcomp_seq
  import tdcomp_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT     = DefaultTimeout,
  parameter int unsigned VOTE_W      = 3,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     start,
  input  logic [$clog2(NCH)-1:0]   ch_sel,
  input  logic [VOTE_W-1:0]        trials,
  input  logic                     chop_en,
  input  logic [NCH-1:0]           edge_p,
  input  logic [NCH-1:0]           edge_n,
  output logic [NCH-1:0]           launch,
  output logic [NCH-1:0]           swap,
  output logic                     busy,
  output logic                     done,
  output logic                     result,
  output logic                     tie,
  output logic                     err,
  output logic [CNT_W-1:0]         delta,
  output logic [VOTE_W:0]          p_votes
);

  localparam int unsigned ChW  = $clog2(NCH);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam int unsigned RecW = $clog2(RECOVER_CYC + 1);

  logic           sync_rst_n;
  logic [NCH-1:0] lvl_p, lvl_n, rise_p, rise_n;

  assign sync_rst_n = rst_n & ena;

  for (genvar i = 0; i < NCH; i++) begin : g_sync
    tdcomp_edge_sync u_sync_p (
      .clk      (clk),
      .rst_n    (sync_rst_n),
      .async_in (edge_p[i]),
      .level    (lvl_p[i]),
      .rise     (rise_p[i])
    );
    tdcomp_edge_sync u_sync_n (
      .clk      (clk),
      .rst_n    (sync_rst_n),
      .async_in (edge_n[i]),
      .level    (lvl_n[i]),
      .rise     (rise_n[i])
    );
  end

  state_e            state_q, state_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [VOTE_W-1:0] trial_q, trial_d;
  logic              chop_q, chop_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [RecW-1:0]   rcnt_q, rcnt_d;
  logic              seen_q, seen_d;
  logic              first_p_q, first_p_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic [VOTE_W:0]   pv_q, pv_d, nv_q, nv_d;
  logic [CNT_W-1:0]  delta_q, delta_d;
  logic              result_q, result_d, tie_q, tie_d, err_q, err_d;
  logic [NCH-1:0]    swap_q, swap_d, launch_q, launch_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [NCH-1:0] sel_oh;
  logic           swapped, p_r, n_r, both_low, at_to, resolve;
  outcome_e       trial_out;

  always_comb begin
    sel_oh        = '0;
    sel_oh[ch_q]  = 1'b1;
    swapped       = |swap_q;
    // De-map so votes always refer to the true inputs.
    p_r           = swapped ? rise_n[ch_q] : rise_p[ch_q];
    n_r           = swapped ? rise_p[ch_q] : rise_n[ch_q];
    both_low      = ~lvl_p[ch_q] & ~lvl_n[ch_q];
    at_to         = (timer_q == TmrW'(TIMEOUT - 1));

    state_d   = state_q;
    ch_d      = ch_q;
    trial_d   = trial_q;
    chop_d    = chop_q;
    timer_d   = timer_q;
    rcnt_d    = rcnt_q;
    seen_d    = seen_q;
    first_p_d = first_p_q;
    dcnt_d    = dcnt_q;
    pv_d      = pv_q;
    nv_d      = nv_q;
    delta_d   = delta_q;
    result_d  = result_q;
    tie_d     = tie_q;
    err_d     = err_q;
    swap_d    = swap_q;
    resolve   = 1'b0;
    trial_out = OutNone;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ch_d     = ch_sel;
          trial_d  = trials;
          chop_d   = chop_en;
          pv_d     = '0;
          nv_d     = '0;
          delta_d  = '0;
          err_d    = 1'b0;
          result_d = 1'b0;
          tie_d    = 1'b0;
          swap_d   = '0;
          timer_d  = '0;
          state_d  = StArm;
        end
      end
      StArm: begin
        if (both_low) begin
          timer_d = '0;
          seen_d  = 1'b0;
          state_d = StRace;
        end else if (at_to) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRace: begin
        timer_d = timer_q + 1'b1;
        if (!seen_q) begin
          if (p_r && n_r) begin
            trial_out = OutTie;
            delta_d   = '0;
            resolve   = 1'b1;
          end else if (p_r || n_r) begin
            if (at_to) begin
              trial_out = p_r ? OutPWin : OutNWin;
              delta_d   = '1;
              resolve   = 1'b1;
            end else begin
              seen_d    = 1'b1;
              first_p_d = p_r;
              dcnt_d    = CNT_W'(1);
            end
          end else if (at_to) begin
            resolve = 1'b1;
          end
        end else if (first_p_q ? n_r : p_r) begin
          trial_out = first_p_q ? OutPWin : OutNWin;
          delta_d   = dcnt_q;
          resolve   = 1'b1;
        end else if (at_to) begin
          trial_out = first_p_q ? OutPWin : OutNWin;
          delta_d   = '1;
          resolve   = 1'b1;
        end else if (dcnt_q != '1) begin
          dcnt_d = dcnt_q + 1'b1;
        end
        if (resolve) begin
          rcnt_d  = '0;
          state_d = StRecover;
          if (chop_q) begin
            swap_d = swapped ? '0 : sel_oh;
          end
        end
      end
      StRecover: begin
        if (rcnt_q == RecW'(RECOVER_CYC - 1)) begin
          if (trial_q != '0) begin
            trial_d = trial_q - 1'b1;
            timer_d = '0;
            state_d = StArm;
          end else begin
            state_d = StDone;
          end
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (trial_out == OutPWin) pv_d = pv_q + 1'b1;
    if (trial_out == OutNWin) nv_d = nv_q + 1'b1;

    // Decision is registered on entry so it is valid in the done cycle.
    if (state_d == StDone && state_q != StDone) begin
      result_d = (pv_d > nv_d);
      tie_d    = (pv_d == nv_d);
      swap_d   = '0;
    end

    launch_d = (state_d == StRace) ? sel_oh : '0;
    busy_d   = (state_d == StArm) || (state_d == StRace) || (state_d == StRecover);
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      trial_q   <= '0;
      chop_q    <= 1'b0;
      timer_q   <= '0;
      rcnt_q    <= '0;
      seen_q    <= 1'b0;
      first_p_q <= 1'b0;
      dcnt_q    <= '0;
      pv_q      <= '0;
      nv_q      <= '0;
      delta_q   <= '0;
      result_q  <= 1'b0;
      tie_q     <= 1'b0;
      err_q     <= 1'b0;
      swap_q    <= '0;
      launch_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      trial_q   <= trial_d;
      chop_q    <= chop_d;
      timer_q   <= timer_d;
      rcnt_q    <= rcnt_d;
      seen_q    <= seen_d;
      first_p_q <= first_p_d;
      dcnt_q    <= dcnt_d;
      pv_q      <= pv_d;
      nv_q      <= nv_d;
      delta_q   <= delta_d;
      result_q  <= result_d;
      tie_q     <= tie_d;
      err_q     <= err_d;
      swap_q    <= swap_d;
      launch_q  <= launch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign launch  = launch_q;
  assign swap    = swap_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign tie     = tie_q;
  assign err     = err_q;
  assign delta   = delta_q;
  assign p_votes = pv_q;

endmodule
